// File: rtl/pll_lock_seq_if.sv
// pll_lock_seq_if: control/status bundle between the PLL lock sequencer and its user.
//   enable   - request PLL operation (level)
//   pll_lock - raw PLL lock indicator, asynchronous to clk
//   pll_en   - PLL enable drive
//   run      - downstream logic enable
//   ce_half  - clk/2 clock-enable, active only while running
//   fault    - retries exhausted, held until enable drops
//   retries  - attempts used since leaving idle
interface pll_lock_seq_if;
    logic       enable;
    logic       pll_lock;
    logic       pll_en;
    logic       run;
    logic       ce_half;
    logic       fault;
    logic [3:0] retries;

    // Controller side: requests operation and supplies the PLL lock pin.
    modport master (
        output enable,
        output pll_lock,
        input  pll_en,
        input  run,
        input  ce_half,
        input  fault,
        input  retries
    );

    // Sequencer side.
    modport slave (
        input  enable,
        input  pll_lock,
        output pll_en,
        output run,
        output ce_half,
        output fault,
        output retries
    );
endinterface

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL power-up and lock qualification sequencer.
// Enables the PLL, waits for lock with a timeout, requires a run of consecutive
// lock cycles before releasing downstream logic, and provides a clk/2 clock
// enable while running. Timeouts and lock losses are retried a bounded number of
// times with the PLL switched off in between; after that a fault is latched
// until enable drops.
// Ports:
//   clk - buffered reference clock (pre-PLL)
//   rst - synchronous active-high reset
//   ctl - pll_lock_seq_if.slave (enable, pll_lock in; pll_en, run, ce_half,
//         fault, retries out; all outputs registered)
module pll_lock_seq #(
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned OFF_CYCLES    = 64,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    pll_lock_seq_if.slave    ctl
);

    localparam int unsigned RETRY_W = 4;

    // Last counter value of each timed state.
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   OFF_LAST     = CNT_W'(OFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_OFF,
        ST_FAULT
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retries_q, retries_d;
    logic                 pll_en_q, pll_en_d;
    logic                 run_q, run_d;
    logic                 ce_half_q, ce_half_d;
    logic                 fault_q, fault_d;
    logic                 lock_meta_q;
    logic                 lock_s_q;
    logic                 attempt_failed;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= ctl.pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            retries_q <= '0;
            pll_en_q  <= 1'b0;
            run_q     <= 1'b0;
            ce_half_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            pll_en_q  <= pll_en_d;
            run_q     <= run_d;
            ce_half_q <= ce_half_d;
            fault_q   <= fault_d;
        end
    end

    // Next state, counter, retry count and next output values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        retries_d      = retries_q;
        attempt_failed = 1'b0;
        pll_en_d       = 1'b0;
        run_d          = 1'b0;
        ce_half_d      = 1'b0;
        fault_d        = 1'b0;

        if (!ctl.enable) begin
            // Dropping enable overrides every other event.
            state_d   = ST_IDLE;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as lock.
                    if (lock_s_q) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        attempt_failed = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    // A lock dropout restarts the wait without using a retry.
                    if (!lock_s_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        attempt_failed = 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cnt_q == OFF_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Timeout or lock loss: power-cycle the PLL while retries remain.
            if (attempt_failed) begin
                cnt_d = '0;
                if (retries_q < RETRY_MAX) begin
                    state_d   = ST_OFF;
                    retries_d = retries_q + RETRY_W'(1);
                end else begin
                    state_d = ST_FAULT;
                end
            end
        end

        // Outputs are decoded from the next state so they switch with it.
        pll_en_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_SETTLE) ||
                   (state_d == ST_RUN);
        run_d    = (state_d == ST_RUN);
        fault_d  = (state_d == ST_FAULT);
        // clk/2 enable: high on the first RUN cycle, then alternating.
        ce_half_d = (state_d == ST_RUN) && ((state_q != ST_RUN) || !ce_half_q);
    end

    assign ctl.pll_en  = pll_en_q;
    assign ctl.run     = run_q;
    assign ctl.ce_half = ce_half_q;
    assign ctl.fault   = fault_q;
    assign ctl.retries = retries_q;

endmodule
